// File: rtl/pong_scoreboard.sv
// pong_scoreboard: BCD match scores with win-by-2 detection, driving a 4-digit
// multiplexed seven-segment display whose winning digits blink once the match ends.
module pong_scoreboard #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 12500000,
    parameter int WIN_SCORE = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       point_r,
    input  logic       point_l,
    input  logic       new_match,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [7:0] score_r,
    output logic [7:0] score_l,
    output logic       game_over,
    output logic [1:0] winner
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_DIV);

    typedef enum logic {PLAY, OVER} state_t;

    state_t        state, state_nx;
    logic [7:0]    score_r_nx, score_l_nx, inc_r, inc_l;
    logic [1:0]    winner_nx;
    logic [SW-1:0] scan_cnt;
    logic [1:0]    idx;
    logic [BW-1:0] blink_cnt;
    logic          blank_phase;
    logic [3:0]    digit;
    logic          win_side, blank;

    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        if (s == 8'h99)
            return s;
        if (s[3:0] == 4'd9)
            return {s[7:4] + 4'd1, 4'd0};
        return {s[7:4], s[3:0] + 4'd1};
    endfunction

    function automatic int bcd_val(input logic [7:0] s);
        return int'(s[7:4]) * 10 + int'(s[3:0]);
    endfunction

    function automatic logic won(input logic [7:0] s, input logic [7:0] o);
        return bcd_val(s) >= WIN_SCORE && bcd_val(s) - bcd_val(o) >= 2;
    endfunction

    function automatic logic [6:0] seven_seg(input logic [3:0] d);
        logic [6:0] r;
        case (d)
            4'd0:    r = 7'h3F;
            4'd1:    r = 7'h06;
            4'd2:    r = 7'h5B;
            4'd3:    r = 7'h4F;
            4'd4:    r = 7'h66;
            4'd5:    r = 7'h6D;
            4'd6:    r = 7'h7D;
            4'd7:    r = 7'h07;
            4'd8:    r = 7'h7F;
            4'd9:    r = 7'h6F;
            default: r = 7'h00;
        endcase
        return r;
    endfunction

    assign inc_r     = bcd_inc(score_r);
    assign inc_l     = bcd_inc(score_l);
    assign game_over = state == OVER;

    // Simultaneous points cancel; the win check sees the post-increment score.
    always_comb begin
        state_nx   = state;
        score_r_nx = score_r;
        score_l_nx = score_l;
        winner_nx  = winner;
        if (new_match) begin
            state_nx   = PLAY;
            score_r_nx = 8'h00;
            score_l_nx = 8'h00;
            winner_nx  = 2'b00;
        end else if (state == PLAY && point_r && !point_l) begin
            score_r_nx = inc_r;
            if (won(inc_r, score_l)) begin
                state_nx  = OVER;
                winner_nx = 2'b01;
            end
        end else if (state == PLAY && point_l && !point_r) begin
            score_l_nx = inc_l;
            if (won(inc_l, score_r)) begin
                state_nx  = OVER;
                winner_nx = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= PLAY;
            score_r <= 8'h00;
            score_l <= 8'h00;
            winner  <= 2'b00;
        end else begin
            state   <= state_nx;
            score_r <= score_r_nx;
            score_l <= score_l_nx;
            winner  <= winner_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt   <= '0;
            blank_phase <= 1'b0;
        end else if (new_match || state != OVER) begin
            blink_cnt   <= '0;
            blank_phase <= 1'b0;
        end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blank_phase <= ~blank_phase;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    // Digit order: right ones, right tens, left ones, left tens.
    assign digit    = idx[1] ? (idx[0] ? score_l[7:4] : score_l[3:0])
                             : (idx[0] ? score_r[7:4] : score_r[3:0]);
    assign win_side = state == OVER && blank_phase && (idx[1] ? winner == 2'b10 : winner == 2'b01);
    assign blank    = win_side || (idx[0] && digit == 4'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
            seg      <= 7'h00;
            an       <= 4'h0;
        end else begin
            scan_cnt <= scan_cnt == SW'(SCAN_DIV - 1) ? '0 : scan_cnt + SW'(1);
            if (scan_cnt == SW'(SCAN_DIV - 1))
                idx <= idx + 2'd1;
            seg <= blank ? 7'h00 : seven_seg(digit);
            an  <= 4'b0001 << idx;
        end
    end
endmodule

// File: tb/tb_pong_scoreboard.sv
// tb_pong_scoreboard: directed and random point/new_match traffic checked every
// cycle against an integer-score model of the match and display scan.
module tb_pong_scoreboard;
    localparam int SD = 4;
    localparam int BD = 8;
    localparam int WS = 11;
    localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic       clk = 0, rst = 0, point_r = 0, point_l = 0, new_match = 0;
    logic [6:0] seg;
    logic [3:0] an;
    logic [7:0] score_r, score_l;
    logic       game_over;
    logic [1:0] winner;

    int total = 0, bad = 0;
    int m_r, m_l, m_win, m_over, edges, over_edges;

    pong_scoreboard #(.SCAN_DIV(SD), .BLINK_DIV(BD), .WIN_SCORE(WS)) dut (
        .clk(clk), .rst(rst), .point_r(point_r), .point_l(point_l), .new_match(new_match),
        .seg(seg), .an(an), .score_r(score_r), .score_l(score_l),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        return 8'((v / 10) * 16 + v % 10);
    endfunction

    task automatic model_reset();
        m_r = 0; m_l = 0; m_win = 0; m_over = 0; edges = 0; over_edges = 0;
    endtask

    task automatic check_reset_values();
        check("rst_seg", 32'(seg), 32'h00);
        check("rst_an", 32'(an), 32'h0);
        check("rst_score_r", 32'(score_r), 32'h00);
        check("rst_score_l", 32'(score_l), 32'h00);
        check("rst_game_over", 32'(game_over), 32'h0);
        check("rst_winner", 32'(winner), 32'h0);
    endtask

    task automatic tick(input bit pr, input bit pl, input bit nm);
        int idx, side, dig;
        bit tens, blank;
        logic [6:0] eseg;
        logic [3:0] ean;
        idx   = (edges / SD) % 4;
        side  = idx < 2 ? m_r : m_l;
        tens  = idx % 2 == 1;
        dig   = tens ? side / 10 : side % 10;
        blank = (tens && dig == 0) ||
                (m_over == 1 && (over_edges / BD) % 2 == 1 && m_win == (idx < 2 ? 1 : 2));
        eseg  = blank ? 7'h00 : SEG_TAB[dig];
        ean   = 4'(1 << idx);
        point_r = pr; point_l = pl; new_match = nm;
        @(posedge clk);
        #1;
        point_r = 0; point_l = 0; new_match = 0;
        edges++;
        if (nm) begin
            m_r = 0; m_l = 0; m_over = 0; m_win = 0; over_edges = 0;
        end else if (m_over == 1) begin
            over_edges++;
        end else if (pr != pl) begin
            if (pr) begin
                m_r = m_r < 99 ? m_r + 1 : 99;
                if (m_r >= WS && m_r - m_l >= 2) begin m_over = 1; m_win = 1; end
            end else begin
                m_l = m_l < 99 ? m_l + 1 : 99;
                if (m_l >= WS && m_l - m_r >= 2) begin m_over = 1; m_win = 2; end
            end
        end
        check("seg", 32'(seg), 32'(eseg));
        check("an", 32'(an), 32'(ean));
        check("score_r", 32'(score_r), 32'(bcd(m_r)));
        check("score_l", 32'(score_l), 32'(bcd(m_l)));
        check("game_over", 32'(game_over), 32'(m_over));
        check("winner", 32'(winner), 32'(m_win));
    endtask

    initial begin
        int x;
        model_reset();
        #12;
        check_reset_values();
        @(negedge clk) rst = 1;
        repeat (18) tick(0, 0, 0);
        repeat (9) tick(1, 0, 0);
        repeat (16) tick(0, 0, 0);
        tick(1, 0, 0);
        repeat (16) tick(0, 0, 0);
        tick(0, 0, 1);
        repeat (11) tick(0, 1, 0);
        for (int i = 0; i < 40; i++) tick(i % 5 == 0, 0, 0);
        tick(0, 0, 1);
        repeat (10) begin tick(1, 0, 0); tick(0, 1, 0); end
        tick(1, 0, 0); tick(0, 1, 0); tick(1, 0, 0); tick(1, 0, 0);
        repeat (20) tick(0, 0, 0);
        tick(0, 0, 1);
        tick(1, 1, 0); tick(1, 0, 0); tick(1, 1, 0); tick(1, 0, 1);
        tick(0, 0, 0);
        repeat (99) begin tick(1, 0, 0); tick(0, 1, 0); end
        tick(1, 0, 0); tick(0, 1, 0); tick(1, 1, 0);
        repeat (16) tick(0, 0, 0);
        tick(0, 0, 1);
        repeat (3) begin tick(1, 0, 0); tick(0, 1, 0); end
        tick(1, 0, 0); tick(1, 0, 0);
        #2 rst = 0;
        #1;
        check_reset_values();
        @(negedge clk) rst = 1;
        model_reset();
        repeat (8) tick(0, 0, 0);
        repeat (3000) begin
            x = int'($urandom_range(0, 99));
            tick((x >= 2 && x < 45) || x >= 95, (x >= 45 && x < 90) || x >= 95, x < 2);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
